// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path (and later the RX side).
//   state_e      : transmitter FSM states, 3-bit encoding
//   TX_IDLE_LVL  : level of an idle serial line (mark)
//   frame_len()  : clk cycles in one frame, start bit through last stop bit
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        WAIT   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_e;

    localparam logic TX_IDLE_LVL = 1'b1;

    // Cycles from the first start-bit cycle to the last stop-bit cycle.
    function automatic int unsigned frame_len(
        input int unsigned data_w,
        input int unsigned parity_en,
        input int unsigned stop_bits,
        input int unsigned clks_per_bit
    );
        return (1 + data_w + parity_en + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Bit-period timer: a down-counter that reloads to CLKS_PER_BIT-1 and raises
// bit_tick_o during the final cycle of every bit period.
//   clk_i      : system clock, rising edge
//   rst_ni     : asynchronous active-low reset (counter cleared)
//   clr_i      : synchronous restart; the next cycle is the first of a period
//   bit_tick_o : high in the last cycle of each CLKS_PER_BIT-cycle period
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic bit_tick_o
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decoded from the registered count, so the tick never depends on clr_i.
    assign bit_tick_o = (cnt_q == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Drains bytes from a synchronous FIFO (rd_en / registered data_out / empty)
// and serialises each as a UART frame: start bit, LSB-first data, optional
// even parity, 1 or 2 stop bits. Back-to-back frames leave a 2-cycle high gap.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO data_out, valid the cycle after the rd_en edge
//   fifo_rd_en : one-cycle pop strobe
//   tx         : serial line, idle high
//   busy       : high from POP through the last stop-bit cycle
//   frame_done : pulse in the final cycle of the last stop bit
// All outputs are Moore decodes of registered state.
// ---------------------------------------------------------------------------
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned FRAME_LEN = frame_len(DATA_W, PARITY_EN, STOP_BITS, CLKS_PER_BIT);
    // The stop period is whatever remains of the frame after start, data, parity.
    localparam int unsigned STOP_LEN  = FRAME_LEN - (1 + DATA_W + PARITY_EN) * CLKS_PER_BIT;
    localparam int unsigned BIT_W     = $clog2(DATA_W + 1);
    localparam int unsigned STOP_W    = $clog2(STOP_LEN);

    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_LEN - 1);

    state_e              state_q,    state_d;
    logic [DATA_W-1:0]   shift_q,    shift_d;
    logic                par_q,      par_d;
    logic [BIT_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [STOP_W-1:0]   stop_cnt_q, stop_cnt_d;

    logic tick_clr;
    logic bit_tick;

    // Restarting the timer in WAIT aligns the first bit period with START.
    assign tick_clr = (state_q == WAIT);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk_i      (clk),
        .rst_ni     (rst),
        .clr_i      (tick_clr),
        .bit_tick_o (bit_tick)
    );

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Registered FIFO output is valid now; later changes on
                // fifo_empty cannot affect this frame.
                shift_d   = fifo_data;
                par_d     = ^fifo_data;
                bit_cnt_d = '0;
                state_d   = START;
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        stop_cnt_d = '0;
                        state_d    = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    stop_cnt_d = '0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (stop_cnt_q == LAST_STOP) begin
                    // Pending data chains straight into the next pop.
                    state_d = fifo_empty ? IDLE : POP;
                end else begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    // Moore output decode; reset forces IDLE so tx rises without a clock edge.
    always_comb begin
        tx = TX_IDLE_LVL;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
            PARITY:  tx = par_q;
            default: tx = TX_IDLE_LVL;
        endcase
    end

    assign fifo_rd_en = (state_q == POP);
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == STOP) && (stop_cnt_q == LAST_STOP);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
// Three transmitters (CLKS_PER_BIT=4) share clock and reset:
//   d0: no parity, 1 stop   d1: even parity, 1 stop   d2: no parity, 2 stop
// Each is fed by a small FIFO model with registered data_out. Bytes written
// for checked frames go into a scoreboard queue and are popped as frames
// are recovered from tx.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [2:0] f_empty;
    logic [2:0] f_rd_en;
    logic [7:0] f_data [3];
    logic [2:0] d_tx;
    logic [2:0] d_busy;
    logic [2:0] d_done;

    logic [7:0] mem [3][8];
    int wp [3]      = '{0, 0, 0};
    int rp [3]      = '{0, 0, 0};
    int pop_cnt [3] = '{0, 0, 0};
    int viol [3]    = '{0, 0, 0};

    logic [7:0] sb_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .fifo_empty(f_empty[0]), .fifo_data(f_data[0]),
        .fifo_rd_en(f_rd_en[0]), .tx(d_tx[0]), .busy(d_busy[0]), .frame_done(d_done[0]));

    fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .fifo_empty(f_empty[1]), .fifo_data(f_data[1]),
        .fifo_rd_en(f_rd_en[1]), .tx(d_tx[1]), .busy(d_busy[1]), .frame_done(d_done[1]));

    fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .fifo_empty(f_empty[2]), .fifo_data(f_data[2]),
        .fifo_rd_en(f_rd_en[2]), .tx(d_tx[2]), .busy(d_busy[2]), .frame_done(d_done[2]));

    assign f_empty[0] = (wp[0] == rp[0]);
    assign f_empty[1] = (wp[1] == rp[1]);
    assign f_empty[2] = (wp[2] == rp[2]);

    // FIFO read side: data_out registered on the rd_en edge.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (f_rd_en[k]) begin
                pop_cnt[k] <= pop_cnt[k] + 1;
                if (wp[k] != rp[k]) begin
                    f_data[k] <= mem[k][rp[k] % 8];
                    rp[k]     <= rp[k] + 1;
                end else begin
                    viol[k] <= viol[k] + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_write(input int k, input logic [7:0] b);
        mem[k][wp[k] % 8] = b;
        wp[k] = wp[k] + 1;
    endtask

    task automatic push(input int k, input logic [7:0] b);
        fifo_write(k, b);
        sb_q.push_back(b);
    endtask

    // Called at a negedge. Waits for the start bit, then samples every cycle
    // of the frame. next_b2b says whether another frame should follow at once.
    task automatic rx_frame(input int k, input int p, input int s,
                            input int exp_wait, input bit gap_check, input bit next_b2b);
        int w, len, slot, bad_hold, bad_busy, stop_bad, gap_busy_low, done_n, done_at;
        logic [7:0] b;
        logic [7:0] e;
        logic par, v, sv;
        w = 0;
        gap_busy_low = 0;
        while (d_tx[k] !== 1'b0 && w < 200) begin
            if (d_busy[k] !== 1'b1) gap_busy_low++;
            @(negedge clk);
            w++;
        end
        chk("start_seen", d_tx[k], 1'b0);
        if (d_tx[k] !== 1'b0) return;
        chk("start_latency", w, exp_wait);
        if (gap_check) chk("gap_busy_low", gap_busy_low, 0);
        len = uart_pkg::frame_len(8, p, s, 4);
        b = '0; par = 1'b0; sv = 1'b0;
        bad_hold = 0; bad_busy = 0; stop_bad = 0; done_n = 0; done_at = -1;
        for (int i = 0; i < len; i++) begin
            v = d_tx[k];
            slot = i / 4;
            if (i % 4 == 0) begin
                sv = v;
                if (slot >= 1 && slot <= 8) b[slot-1] = v;
                else if (p != 0 && slot == 9) par = v;
                else if (slot >= 9 + p && v !== 1'b1) stop_bad++;
            end else if (v !== sv) begin
                bad_hold++;
            end
            if (d_busy[k] !== 1'b1) bad_busy++;
            if (d_done[k] === 1'b1) begin
                done_n++;
                done_at = i;
            end
            @(negedge clk);
        end
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else e = 8'hxx;
        $display("frame d%0d: byte %02h expected %02h parity %0b latency %0d done_at %0d",
                 k, b, e, par, w, done_at);
        chk("byte", b, e);
        if (p != 0) chk("parity", par, ^e);
        chk("bit_hold", bad_hold, 0);
        chk("stop_level", stop_bad, 0);
        chk("busy_in_frame", bad_busy, 0);
        chk("done_count", done_n, 1);
        chk("done_pos", done_at, len - 1);
        chk("after_tx", d_tx[k], 1'b1);
        chk("after_busy", d_busy[k], next_b2b);
        chk("after_rd_en", f_rd_en[k], next_b2b);
    endtask

    initial begin
        int cnt_rd, cnt_busy, w;

        // Reset state
        #1;
        chk("reset_tx", d_tx, 3'b111);
        chk("reset_busy", d_busy, 3'b000);
        chk("reset_rd_en", f_rd_en, 3'b000);
        chk("reset_done", d_done, 3'b000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a start bit
        fifo_write(0, 8'h5A);
        w = 0;
        while (d_tx[0] !== 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("t1_start_seen", d_tx[0], 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t1_async_tx", d_tx[0], 1'b1);
        chk("t1_async_busy", d_busy[0], 1'b0);
        chk("t1_async_rd_en", f_rd_en[0], 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cnt_rd = 0; cnt_busy = 0;
        repeat (20) begin
            @(negedge clk);
            if (f_rd_en[0]) cnt_rd++;
            if (d_busy[0] || d_tx[0] !== 1'b1) cnt_busy++;
        end
        chk("t1_rd_en_after", cnt_rd, 0);
        chk("t1_idle_after", cnt_busy, 0);
        chk("t1_pops", pop_cnt[0], 1);

        // Single byte, no parity
        push(0, 8'hA5);
        rx_frame(0, 0, 1, 3, 1'b0, 1'b0);
        chk("t2_pops", pop_cnt[0], 2);

        // Even parity
        repeat (3) @(negedge clk);
        push(1, 8'hA5);
        rx_frame(1, 1, 1, 3, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        push(1, 8'h07);
        rx_frame(1, 1, 1, 3, 1'b0, 1'b0);
        chk("t3_pops", pop_cnt[1], 2);

        // Back-to-back frames
        repeat (3) @(negedge clk);
        push(0, 8'h01);
        push(0, 8'h02);
        push(0, 8'h03);
        rx_frame(0, 0, 1, 3, 1'b0, 1'b1);
        rx_frame(0, 0, 1, 2, 1'b1, 1'b1);
        rx_frame(0, 0, 1, 2, 1'b1, 1'b0);
        chk("t4_pops", pop_cnt[0], 5);

        // Two stop bits
        repeat (3) @(negedge clk);
        push(2, 8'hFF);
        rx_frame(2, 0, 2, 3, 1'b0, 1'b0);
        chk("t5_pops", pop_cnt[2], 1);

        // Empty drops for one byte only, reasserting during WAIT
        repeat (3) @(negedge clk);
        push(0, 8'h3C);
        rx_frame(0, 0, 1, 3, 1'b0, 1'b0);
        cnt_rd = 0;
        repeat (20) begin
            @(negedge clk);
            if (f_rd_en[0]) cnt_rd++;
        end
        chk("t6_no_second_pop", cnt_rd, 0);
        chk("t6_pops", pop_cnt[0], 6);
        chk("t6_idle_busy", d_busy[0], 1'b0);
        chk("pop_while_empty", viol[0] + viol[1] + viol[2], 0);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream consumer of the team's 8-bit synchronous circular-buffer FIFO. Pops one byte at a time through the FIFO's rd_en/data_out/empty interface and serialises it as an asynchronous UART frame: start bit, LSB-first data, optional even parity, stop bit(s). It is the drain stage between the TX FIFO and the chip's serial pin.

Parameters:
DATA_W, 8, data bits per frame; must match the FIFO data width
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range is 2 or more
PARITY_EN, 0, 1 inserts an even-parity bit after the data bits
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_W  FIFO data_out; registered, valid the cycle after the rd_en edge
fifo_rd_en  output  1  one-cycle pop strobe to the FIFO rd_en
tx  output  1  serial line, idle high
busy  output  1  high from POP through the last stop-bit cycle
frame_done  output  1  one-cycle pulse in the final cycle of the last stop bit

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, all counters and the shift register cleared. A reset mid-frame aborts immediately. The in-flight byte is lost, and tx goes high without waiting for a clock edge.
- All outputs are registered or pure Moore decodes of registered state. No combinational path exists from inputs to outputs.
- FSM states: IDLE, POP, WAIT, START, DATA, PARITY, STOP.
- IDLE: tx=1. If fifo_empty=0 at an edge, go to POP. Otherwise stay in IDLE.
- POP: fifo_rd_en=1 for exactly this one cycle. Next state is WAIT unconditionally.
- WAIT: fifo_data is now valid. At the end of this cycle, capture fifo_data into the shift register, clear the bit-tick counter, and go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit counter.
  - After DATA_W bits, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: tx = XOR-reduction of the captured byte (even parity) for CLKS_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done=1 in the last of those cycles.
  - Then go to POP if fifo_empty=0 at that edge (back-to-back, no idle bit), else to IDLE.
- Latency: the start bit appears 3 cycles after the IDLE edge that sees fifo_empty=0 (POP, WAIT, then START). Back-to-back frames have a 2-cycle high gap (POP+WAIT) between the stop bit and the next start bit.
- Frame length (START..STOP) = (1 + DATA_W + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, exactly.
- Pop rules:
  - fifo_rd_en is never asserted while fifo_empty=1 is sampled in the deciding state.
  - At most one pop per frame.
  - No pop in any state other than POP.
- fifo_empty rising after POP has no effect on the current frame.
- Width rules:
  - Tick counter is $clog2(CLKS_PER_BIT) bits and wraps at CLKS_PER_BIT-1.
  - Bit counter is $clog2(DATA_W+1) bits.
  - The stop counter covers STOP_BITS*CLKS_PER_BIT.
- Inputs are assumed synchronous to clk. No input synchronisers.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE..STOP) with 3-bit encoding;
  - localparam TX_IDLE_LVL=1'b1;
  - helper function for the frame-length calculation, used by both RTL and bench.
- One natural sub-module: uart_baud_tick. It is a CLKS_PER_BIT down-counter with a synchronous clear input and a one-cycle bit_tick output, reused later by the RX side. All FSM logic stays in fifo_uart_tx.

Test Plan:
1. Reset/idle: rst=0 mid-start-bit of a frame, then release, with fifo_empty=1 → tx=1 immediately (asynchronous), busy=0, fifo_rd_en never asserted.
2. Single byte, CLKS_PER_BIT=4, PARITY_EN=0, fifo_data=8'hA5 →
   - exactly one rd_en pulse;
   - tx = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total);
   - start bit 3 cycles after empty drops;
   - one frame_done pulse.
3. Parity, PARITY_EN=1, bytes 8'hA5 then 8'h07 → parity bit is 0 for 8'hA5 and 1 for 8'h07; frame length is 44 cycles.
4. Back-to-back: FIFO preloaded with 8'h01, 8'h02, 8'h03 → three pops; a 2-cycle high gap between stop and the next start; recovered bytes 01, 02, 03 in order; busy high throughout.
5. STOP_BITS=2, byte 8'hFF → stop period is 8 cycles high; frame_done is asserted only in the 8th cycle.
6. Empty boundary: fifo_empty deasserts for exactly one byte and reasserts in WAIT → the frame completes normally, then IDLE with no second pop.
